survive_acs: RTL and testbench
==============================

// Module: survive_acs
// PURPOSE
//  Survivor-metric unit of the turbo-decoder trellis stage. Takes four trellis steps of soft
//  (systematic, parity) pairs and runs add-compare-select (ACS) over a 4-state RSC (1,5/7) trellis
//  starting from state 0. Outputs the 14 node metrics (stage1: 2 nodes, stages 2-4: 4 nodes each)
//  and the surviving predecessor for each node, for the traceback/LLR logic downstream.
// PARAMETERS
//  IN_W   16  soft-input width, sign-magnitude: bit15 = sign (1 = negative), [14:0] = magnitude
//  MET_W  28  signed two's-complement metric width
//  OUT_W  30  output width = 2 (predecessor) + MET_W
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-low reset
//  m11..m41   in   16  systematic soft value, steps 1..4 (mk1 = step k)
//  m12..m42   in   16  parity soft value, steps 1..4 (mk2 = step k)
//  v_1..v_14  out  30  node word {pred[1:0], metric[27:0]}
// BEHAVIOUR
//  - Interface decided: one clock (clk); reset rst is synchronous and active-low.
//  - Reset: while rst==0 at a clk edge, all input registers and all v_n clear to 0.
//  - Cycle 1: register all eight inputs.
//  - Cycle 2: compute all 14 nodes combinationally from the registered inputs; register to v_n.
//  - Latency is 2 clocks. A new input set is accepted every cycle; no handshake.
//  - Conversion: sign-magnitude to two's complement, sign-extended to MET_W.
//    0x8000 (negative zero) -> 0.
//  - Trellis: state = {s1,s0}; feedback a = u^s1^s0; parity p = a^s0; next state = {a,s1}.
//  - Branch metric at step k: (u ? +Sk : -Sk) + (p ? +Pk : -Pk).
//  - Stage 1 starts from state 0:
//    - v_1 = state 0 (u=0); v_2 = state 2 (u=1); pred = 0 for both.
//  - Stage 2, from stage-1 states {0,2}:
//    - Each state has exactly one predecessor: state 0 <- 0, state 1 <- 2, state 2 <- 0,
//      state 3 <- 2.
//    - v_3..v_6 = states 0..3.
//  - Stages 3 and 4 (v_7..v_10, v_11..v_14 = states 0..3):
//    - Two predecessors each; select the maximum of (pred metric + BM).
//    - Tie -> lower predecessor index.
//    - pred field = selected predecessor state.
//  - Widths: worst case |metric| = 8*32767 < 2^27, so no saturation is needed and none is applied.
// CONFIGURATION
//  - SURVIVE_NORM_EN defined:
//    - Within stages 3 and 4, subtract that stage's maximum metric from every node of that stage.
//    - The best node of each stage reads 0; all others are <= 0.
//    - Normalisation is applied to the output only; ACS uses un-normalised values.
//    - Selection is unchanged.
//  - SURVIVE_NORM_EN undefined: raw accumulated metrics are output.
// STRUCTURE
//  - Shared package turbo_pkg:
//    - IN_W, MET_W, and the metric_t typedef.
//    - Trellis next-state/parity function (next_state(s,u), parity(s,u)).
//    - sm2tc() conversion function.
//  - One sub-module survive_acs2: 2-way add-compare-select.
//    - Inputs: two metrics + two BMs.
//    - Outputs: metric + 1-bit select.
//    - Instantiated 8x (stages 3 and 4).
// TESTING
//  - Reset: rst=0 for 5 cycles with random inputs -> all v_n == 0.
//    Release -> valid outputs 2 cycles later.
//  - Mixed vector: m11=0x801E, m12=0x8064, m21=100, m22=0x8032, m31=100, m32=0x8064,
//    m41=0x8064, m42=0x8064.
//    - Stage 1: v_1 metric=130 pred 0; v_2 metric=-130 pred 0.
//    - Stage 2: v_3=80/pred0, v_4=20/pred2, v_5=180/pred0, v_6=-280/pred2.
//  - All inputs 0 -> all metrics 0; all stage-3/4 preds = lower index (0,2,0,2 for states 0..3).
//  - Negative zero: all inputs 0x8000 -> identical to the all-zero result.
//  - Full scale: all inputs 0x7FFF -> v_1=-65534, v_2=+65534; no overflow at stage 4
//    (check against a golden model).
//  - Random 10k vectors vs. a behavioural model, with and without SURVIVE_NORM_EN.
//    - Back-to-back inputs must each appear exactly 2 cycles later.

Source files
------------

// File: rtl/turbo_pkg.sv
// ---------------------------------------------------------------------------
// turbo_pkg - shared definitions for the turbo-decoder trellis stage.
//   IN_W / MET_W / OUT_W : soft-input, metric and node-word widths
//   metric_t             : signed metric type
//   next_state(s,u)      : RSC (1,5/7) next state, state = {s1,s0}
//   parity(s,u)          : RSC parity output
//   sm2tc(x)             : sign-magnitude soft value -> signed metric
//   bm(u,p,S,P)          : branch metric for one trellis edge
// ---------------------------------------------------------------------------
package turbo_pkg;

    localparam int IN_W  = 16;
    localparam int MET_W = 28;
    localparam int OUT_W = 2 + MET_W;

    typedef logic signed [MET_W-1:0] metric_t;

    // Feedback bit a = u^s1^s0 becomes the new MSB; s1 shifts down.
    function automatic logic [1:0] next_state(input logic [1:0] s, input logic u);
        logic a;
        a = u ^ s[1] ^ s[0];
        return {a, s[1]};
    endfunction

    function automatic logic parity(input logic [1:0] s, input logic u);
        return (u ^ s[1] ^ s[0]) ^ s[0];
    endfunction

    // Negative zero (0x8000) naturally maps to 0.
    function automatic metric_t sm2tc(input logic [IN_W-1:0] x);
        metric_t mag;
        mag = {{(MET_W-IN_W+1){1'b0}}, x[IN_W-2:0]};
        return x[IN_W-1] ? -mag : mag;
    endfunction

    function automatic metric_t bm(input logic u, input logic p,
                                   input metric_t s, input metric_t pp);
        return (u ? s : -s) + (p ? pp : -pp);
    endfunction

endpackage

// File: rtl/survive_acs2.sv
// ---------------------------------------------------------------------------
// survive_acs2 - 2-way add-compare-select (combinational).
//   i_m0, i_m1 : predecessor metrics (lower / higher predecessor index)
//   i_b0, i_b1 : branch metrics of the two incoming edges
//   o_m        : surviving metric
//   o_sel      : 1 when the higher-index predecessor survives
// A tie keeps the lower-index predecessor (strict compare).
// ---------------------------------------------------------------------------
module survive_acs2
    import turbo_pkg::*;
(
    input  metric_t i_m0,
    input  metric_t i_m1,
    input  metric_t i_b0,
    input  metric_t i_b1,
    output metric_t o_m,
    output logic    o_sel
);

    metric_t w_c0;
    metric_t w_c1;

    assign w_c0  = i_m0 + i_b0;
    assign w_c1  = i_m1 + i_b1;
    assign o_sel = (w_c1 > w_c0);
    assign o_m   = o_sel ? w_c1 : w_c0;

endmodule

// File: rtl/survive_acs.sv
// ---------------------------------------------------------------------------
// survive_acs - survivor-metric unit, 4-step ACS over the 4-state RSC (1,5/7)
// trellis starting in state 0. Two-cycle latency, one input set per cycle.
//   clk          : clock, rising edge
//   rst          : synchronous active-low reset
//   mk1 / mk2    : systematic / parity soft input of step k (sign-magnitude)
//   v_1..v_14    : node words {pred[1:0], metric[27:0]}
//                  v_1,v_2 = stage-1 states 0,2; v_3..v_6, v_7..v_10,
//                  v_11..v_14 = states 0..3 of stages 2, 3, 4
// Build option: SURVIVE_NORM_EN - subtract each stage's maximum from the
// stage-3 and stage-4 output metrics (ACS itself stays un-normalised).
// ---------------------------------------------------------------------------
module survive_acs
    import turbo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  m11,
    input  logic [IN_W-1:0]  m12,
    input  logic [IN_W-1:0]  m21,
    input  logic [IN_W-1:0]  m22,
    input  logic [IN_W-1:0]  m31,
    input  logic [IN_W-1:0]  m32,
    input  logic [IN_W-1:0]  m41,
    input  logic [IN_W-1:0]  m42,
    output logic [OUT_W-1:0] v_1,
    output logic [OUT_W-1:0] v_2,
    output logic [OUT_W-1:0] v_3,
    output logic [OUT_W-1:0] v_4,
    output logic [OUT_W-1:0] v_5,
    output logic [OUT_W-1:0] v_6,
    output logic [OUT_W-1:0] v_7,
    output logic [OUT_W-1:0] v_8,
    output logic [OUT_W-1:0] v_9,
    output logic [OUT_W-1:0] v_10,
    output logic [OUT_W-1:0] v_11,
    output logic [OUT_W-1:0] v_12,
    output logic [OUT_W-1:0] v_13,
    output logic [OUT_W-1:0] v_14
);

    // r_in[2k] = systematic, r_in[2k+1] = parity of step k+1
    logic [IN_W-1:0]  r_in [8];
    logic [OUT_W-1:0] r_v  [14];
    logic [OUT_W-1:0] w_v  [14];

    metric_t w_S [4];
    metric_t w_P [4];
    metric_t w_s1 [2];        // stage 1: idx 0 = state 0, idx 1 = state 2
    metric_t w_met2 [4];
    metric_t w_met34 [2][4];  // [0] = stage 3, [1] = stage 4
    logic    w_sel34 [2][4];
    metric_t w_norm [2][4];

    for (genvar k = 0; k < 4; k++) begin : g_conv
        assign w_S[k] = sm2tc(r_in[2*k]);
        assign w_P[k] = sm2tc(r_in[2*k+1]);
    end

    assign w_s1[0] = bm(1'b0, parity(2'd0, 1'b0), w_S[0], w_P[0]);
    assign w_s1[1] = bm(1'b1, parity(2'd0, 1'b1), w_S[0], w_P[0]);

    // Stage 2: only states 0 and 2 are live, so every node has the single
    // predecessor {ns[0],0}; input bit recovered from a = u^s1^s0.
    for (genvar n = 0; n < 4; n++) begin : g_st2
        localparam logic [1:0] NS = 2'(n);
        localparam logic [1:0] PR = {NS[0], 1'b0};
        localparam logic       U  = NS[1] ^ PR[1] ^ PR[0];
        assign w_met2[n] = w_s1[NS[0]] + bm(U, parity(PR, U), w_S[1], w_P[1]);
    end

    // Stages 3/4: predecessors of ns are {ns[0],0} and {ns[0],1}.
    for (genvar j = 0; j < 2; j++) begin : g_st
        for (genvar n = 0; n < 4; n++) begin : g_ns
            localparam logic [1:0] NS = 2'(n);
            localparam logic [1:0] P0 = {NS[0], 1'b0};
            localparam logic [1:0] P1 = {NS[0], 1'b1};
            localparam logic       U0 = NS[1] ^ P0[1] ^ P0[0];
            localparam logic       U1 = NS[1] ^ P1[1] ^ P1[0];
            metric_t w_pm0, w_pm1, w_b0, w_b1;

            assign w_b0 = bm(U0, parity(P0, U0), w_S[j+2], w_P[j+2]);
            assign w_b1 = bm(U1, parity(P1, U1), w_S[j+2], w_P[j+2]);

            if (j == 0) begin : g_prev
                assign w_pm0 = w_met2[P0];
                assign w_pm1 = w_met2[P1];
            end else begin : g_prev
                assign w_pm0 = w_met34[0][P0];
                assign w_pm1 = w_met34[0][P1];
            end

            survive_acs2 u_acs (
                .i_m0  (w_pm0),
                .i_m1  (w_pm1),
                .i_b0  (w_b0),
                .i_b1  (w_b1),
                .o_m   (w_met34[j][n]),
                .o_sel (w_sel34[j][n])
            );
        end
    end

`ifdef SURVIVE_NORM_EN
    metric_t w_max [2];

    always_comb begin
        for (int j = 0; j < 2; j++) begin
            w_max[j] = w_met34[j][0];
            for (int n = 1; n < 4; n++)
                if (w_met34[j][n] > w_max[j]) w_max[j] = w_met34[j][n];
            for (int n = 0; n < 4; n++)
                w_norm[j][n] = w_met34[j][n] - w_max[j];
        end
    end
`else
    always_comb begin
        for (int j = 0; j < 2; j++)
            for (int n = 0; n < 4; n++)
                w_norm[j][n] = w_met34[j][n];
    end
`endif

    always_comb begin
        w_v[0] = {2'b00, w_s1[0]};
        w_v[1] = {2'b00, w_s1[1]};
        for (int n = 0; n < 4; n++)
            w_v[2+n] = {n[0], 1'b0, w_met2[n]};
        for (int j = 0; j < 2; j++)
            for (int n = 0; n < 4; n++)
                w_v[6+4*j+n] = {n[0], w_sel34[j][n], w_norm[j][n]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++)  r_in[i] <= '0;
            for (int i = 0; i < 14; i++) r_v[i]  <= '0;
        end else begin
            r_in[0] <= m11;  r_in[1] <= m12;
            r_in[2] <= m21;  r_in[3] <= m22;
            r_in[4] <= m31;  r_in[5] <= m32;
            r_in[6] <= m41;  r_in[7] <= m42;
            r_v     <= w_v;
        end
    end

    assign v_1  = r_v[0];   assign v_2  = r_v[1];
    assign v_3  = r_v[2];   assign v_4  = r_v[3];
    assign v_5  = r_v[4];   assign v_6  = r_v[5];
    assign v_7  = r_v[6];   assign v_8  = r_v[7];
    assign v_9  = r_v[8];   assign v_10 = r_v[9];
    assign v_11 = r_v[10];  assign v_12 = r_v[11];
    assign v_13 = r_v[12];  assign v_14 = r_v[13];

endmodule

// File: tb/tb_survive_acs.sv
module tb_survive_acs;

    typedef logic [7:0][15:0]  in_t;
    typedef logic [13:0][29:0] out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    in_t         mi  = '0;
    logic [29:0] v [14];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    survive_acs dut (
        .clk (clk), .rst (rst),
        .m11 (mi[0]), .m12 (mi[1]), .m21 (mi[2]), .m22 (mi[3]),
        .m31 (mi[4]), .m32 (mi[5]), .m41 (mi[6]), .m42 (mi[7]),
        .v_1 (v[0]),  .v_2 (v[1]),  .v_3 (v[2]),  .v_4 (v[3]),
        .v_5 (v[4]),  .v_6 (v[5]),  .v_7 (v[6]),  .v_8 (v[7]),
        .v_9 (v[8]),  .v_10(v[9]),  .v_11(v[10]), .v_12(v[11]),
        .v_13(v[12]), .v_14(v[13])
    );

    task automatic chk(input string tag, input logic [29:0] obs, input logic [29:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sm(input logic [15:0] x);
        int mag;
        mag = int'(x[14:0]);
        return x[15] ? -mag : mag;
    endfunction

    // Forward trellis recursion over all reachable states; ties keep the
    // first (lowest-index) predecessor seen.
    function automatic out_t model(input in_t x);
        out_t o;
        int met [4], nmet [4], pr [4], mx, s, p, a, par, ns, c, idx;
        bit reach [4], nreach [4];
        o = '0;
        for (int i = 0; i < 4; i++) begin met[i] = 0; reach[i] = (i == 0); end
        for (int k = 0; k < 4; k++) begin
            s = sm(x[2*k]);
            p = sm(x[2*k+1]);
            for (int i = 0; i < 4; i++) begin nreach[i] = 0; nmet[i] = 0; pr[i] = 0; end
            for (int ps = 0; ps < 4; ps++) begin
                if (!reach[ps]) continue;
                for (int u = 0; u < 2; u++) begin
                    a   = u ^ (ps >> 1) ^ (ps & 1);
                    par = a ^ (ps & 1);
                    ns  = (a << 1) | (ps >> 1);
                    c   = met[ps] + (u != 0 ? s : -s) + (par != 0 ? p : -p);
                    if (!nreach[ns] || c > nmet[ns]) begin
                        nmet[ns] = c; pr[ns] = ps; nreach[ns] = 1;
                    end
                end
            end
            mx = 0;
`ifdef SURVIVE_NORM_EN
            if (k >= 2) begin
                mx = nmet[0];
                for (int i = 1; i < 4; i++) if (nmet[i] > mx) mx = nmet[i];
            end
`endif
            for (int i = 0; i < 4; i++) begin
                if (!nreach[i]) continue;
                idx = (k == 0) ? (i >> 1) : (2 + 4*(k-1) + i);
                o[idx] = {2'(pr[i]), 28'(nmet[i] - mx)};
            end
            met = nmet;
            reach = nreach;
        end
        return o;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] r;
        case ($urandom_range(0, 3))
            0: r = 16'($urandom);
            1: r = {1'($urandom), 15'($urandom_range(0, 3))};
            2: r = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'hFFFF;
            default: r = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
        endcase
        return r;
    endfunction

    task automatic run_vec(input in_t x, input string name);
        out_t e;
        mi = x;
        @(posedge clk); @(posedge clk); #1;
        e = model(x);
        for (int i = 0; i < 14; i++) chk($sformatf("%s v_%0d", name, i+1), v[i], e[i]);
    endtask

    in_t  x;
    out_t q [$];
    out_t e;

    initial begin
        // reset with random inputs
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 8; i++) mi[i] = 16'($urandom);
            @(posedge clk); #1;
            for (int i = 0; i < 14; i++) chk($sformatf("reset v_%0d", i+1), v[i], 30'd0);
        end
        rst = 1'b1;

        // mixed vector
        x = {16'h8064, 16'h8064, 16'h8064, 16'd100, 16'h8032, 16'd100, 16'h8064, 16'h801E};
        run_vec(x, "mixed");
        chk("mixed v_1 const", v[0], {2'd0, 28'(130)});
        chk("mixed v_2 const", v[1], {2'd0, 28'(-130)});
        chk("mixed v_3 const", v[2], {2'd0, 28'(80)});
        chk("mixed v_4 const", v[3], {2'd2, 28'(20)});
        chk("mixed v_5 const", v[4], {2'd0, 28'(180)});
        chk("mixed v_6 const", v[5], {2'd2, 28'(-280)});

        // all zero and negative zero
        x = '0;
        run_vec(x, "zero");
        for (int i = 6; i < 14; i++)
            chk($sformatf("zero v_%0d const", i+1), v[i], {((i % 2) != 0) ? 2'd2 : 2'd0, 28'd0});
        x = {8{16'h8000}};
        run_vec(x, "negzero");
        for (int i = 0; i < 14; i++)
            chk($sformatf("negzero v_%0d const", i+1), v[i],
                {(i >= 2 && (i % 2) != 0) ? 2'd2 : 2'd0, 28'd0});

        // full scale
        x = {8{16'h7FFF}};
        run_vec(x, "full");
        chk("full v_1 const", v[0], {2'd0, 28'(-65534)});
        chk("full v_2 const", v[1], {2'd0, 28'(65534)});
        x = {8{16'hFFFF}};
        run_vec(x, "fullneg");

        // back-to-back random stream, each result due two edges later
        for (int t = 0; t < 10002; t++) begin
            @(posedge clk); #1;
            if (q.size() == 2 || (t >= 10000 && q.size() > 0)) begin
                e = q.pop_front();
                for (int i = 0; i < 14; i++) chk($sformatf("rand%0d v_%0d", t, i+1), v[i], e[i]);
            end
            if (t < 10000) begin
                for (int i = 0; i < 8; i++) x[i] = rnd16();
                mi = x;
                q.push_back(model(x));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
